// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_arb_pkg: state encoding and default widths for the SDRAM arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_ADDR_W      = 23;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 1023;

  // Index width for an N-entry channel set; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter: combinational rotate-priority pick, first requester after 'last'.
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // rot[j] is the request of channel (last+1+j) mod N; lowest set j wins.
  always_comb begin
    dbl     = {req, req} >> (int'(last) + 1);
    rot     = dbl[N-1:0];
    gnt_idx = '0;
    any     = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        gnt_idx = IW'((int'(last) + 1 + j) % N);
        any     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_arbiter: round-robin multi-client front end for the SDRAM Avalon-MM port.
// Optional SDRAM_ARB_TIMEOUT_EN adds a per-transaction timeout. Rev 1.0
// ----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BE_W        = DATA_W / 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_writedata,
  input  logic [NUM_CH*BE_W-1:0]   ch_byteenable,
  output logic [DATA_W-1:0]        ch_readdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [ADDR_W-1:0]        sdram_address,
  output logic [BE_W-1:0]          sdram_byteenable_n,
  output logic                     sdram_chipselect,
  output logic [DATA_W-1:0]        sdram_writedata,
  output logic                     sdram_read_n,
  output logic                     sdram_write_n,
  input  logic [DATA_W-1:0]        sdram_readdata,
  input  logic                     sdram_readdatavalid,
  input  logic                     sdram_waitrequest
);

  localparam int IW = idx_w(NUM_CH);

  arb_state_t        state, next_state;
  logic [NUM_CH-1:0] req_vec;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     grant;
  logic [IW-1:0]     pick;
  logic              pick_any;
  logic [NUM_CH-1:0] grant_onehot;

  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              sel_write;

  logic              timeout_hit;
  logic              capture_rd;
  logic              in_issue;

  assign req_vec      = ch_read | ch_write;
  assign grant_onehot = NUM_CH'(1) << grant;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_rr (
    .req     (req_vec),
    .last    (last_grant),
    .gnt_idx (pick),
    .any     (pick_any)
  );

  // Slice out the candidate's request; write wins when both strobes are set.
  always_comb begin
    sel_addr  = ch_addr[int'(pick)*ADDR_W +: ADDR_W];
    sel_wdata = ch_writedata[int'(pick)*DATA_W +: DATA_W];
    sel_be    = ch_byteenable[int'(pick)*BE_W +: BE_W];
    sel_write = ch_write[pick];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_any) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (timeout_hit) begin
          next_state = RESP;
        end else if (!sdram_waitrequest) begin
          next_state = op_write ? RESP : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (timeout_hit || sdram_readdatavalid) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign capture_rd = (state == WAIT_RD) && sdram_readdatavalid && !timeout_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant  <= IW'(NUM_CH - 1);
      grant       <= '0;
      op_write    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      ch_readdata <= '0;
      ch_done     <= '0;
    end else begin
      if ((state == IDLE) && pick_any) begin
        grant      <= pick;
        last_grant <= pick;
        op_write   <= sel_write;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        be_q       <= sel_be;
      end
      if (capture_rd) begin
        ch_readdata <= sdram_readdata;
      end
      // RESP is only entered from ISSUE/WAIT_RD, so grant is stable here.
      ch_done <= (next_state == RESP) ? grant_onehot : '0;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;

  assign timeout_hit = ((state == ISSUE) || (state == WAIT_RD)) &&
                       (to_cnt == TW'(TIMEOUT_CYC));

  // Held at zero in IDLE so it reads 0 in the first ISSUE cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt <= '0;
      ch_err <= '0;
    end else begin
      if (state == IDLE) begin
        to_cnt <= '0;
      end else if (((state == ISSUE) || (state == WAIT_RD)) && !timeout_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end
      ch_err <= ((next_state == RESP) && timeout_hit) ? grant_onehot : '0;
    end
  end
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign ch_err             = '0;
`endif

  assign in_issue           = (state == ISSUE);
  assign sdram_chipselect   = in_issue;
  assign sdram_read_n       = !(in_issue && !op_write);
  assign sdram_write_n      = !(in_issue && op_write);
  assign sdram_byteenable_n = in_issue ? ~be_q : '1;
  assign sdram_address      = addr_q;
  assign sdram_writedata    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// tb_sdram_arbiter: scoreboard bench with a small Avalon controller model.
// Expected commands/completions are queued at request time, checked on output.
module tb_sdram_arbiter;

  localparam int NUM_CH      = 4;
  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 32;
  localparam int BE_W        = 4;
  localparam int TIMEOUT_CYC = 15;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*DATA_W-1:0] ch_writedata;
  logic [NUM_CH*BE_W-1:0]   ch_byteenable;
  logic [DATA_W-1:0]        ch_readdata;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_err;
  logic [ADDR_W-1:0]        sdram_address;
  logic [BE_W-1:0]          sdram_byteenable_n;
  logic                     sdram_chipselect;
  logic [DATA_W-1:0]        sdram_writedata;
  logic                     sdram_read_n;
  logic                     sdram_write_n;
  logic [DATA_W-1:0]        sdram_readdata;
  logic                     sdram_readdatavalid;
  logic                     sdram_waitrequest;

  sdram_arbiter #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .BE_W        (BE_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .ch_addr             (ch_addr),
    .ch_read             (ch_read),
    .ch_write            (ch_write),
    .ch_writedata        (ch_writedata),
    .ch_byteenable       (ch_byteenable),
    .ch_readdata         (ch_readdata),
    .ch_done             (ch_done),
    .ch_err              (ch_err),
    .sdram_address       (sdram_address),
    .sdram_byteenable_n  (sdram_byteenable_n),
    .sdram_chipselect    (sdram_chipselect),
    .sdram_writedata     (sdram_writedata),
    .sdram_read_n        (sdram_read_n),
    .sdram_write_n       (sdram_write_n),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid),
    .sdram_waitrequest   (sdram_waitrequest)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be_n;
    logic [DATA_W-1:0] rdata;
  } cmd_t;

  typedef struct {
    int                ch;
    logic              rd;
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                due;
  } done_t;

  cmd_t              exp_cmd[$];
  done_t             exp_done[$];
  int                vectors     = 0;
  int                miscompares = 0;
  int                cyc         = 0;
  int                stall_cfg   = 0;
  int                stall_cnt   = 0;
  int                rd_lat      = 0;
  int                rd_cnt      = 0;
  int                last_done   = -1;
  logic [DATA_W-1:0] rd_val      = '0;
  logic [DATA_W-1:0] hold_rdata  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: completion monitor, then controller model, both at the negedge.
  task automatic tick();
    done_t e;
    cmd_t  c;
    @(negedge i_clk);
    cyc++;
    last_done = -1;
    if (ch_done != '0 || ch_err != '0) begin
      if (exp_done.size() == 0) begin
        chk("done_unexpected", 64'({ch_err, ch_done}), 64'd0);
      end else begin
        e = exp_done.pop_front();
        chk("done_vec", 64'(ch_done), 64'(1) << e.ch);
        chk("err_vec", 64'(ch_err), e.err ? (64'(1) << e.ch) : 64'd0);
        if (e.err) begin
          chk("rdata_hold", 64'(ch_readdata), 64'(hold_rdata));
        end else if (e.rd) begin
          chk("rdata", 64'(ch_readdata), 64'(e.rdata));
          hold_rdata = e.rdata;
        end
        if (e.due >= 0) chk("done_cycle", 64'(cyc), 64'(e.due));
        last_done = e.ch;
      end
      ch_read  = ch_read & ~ch_done;
      ch_write = ch_write & ~ch_done;
    end

    sdram_readdatavalid = 1'b0;
    sdram_readdata      = $urandom;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = rd_val;
      end
    end
    if (sdram_chipselect && (!sdram_read_n || !sdram_write_n)) begin
      if (stall_cnt < stall_cfg) begin
        sdram_waitrequest = 1'b1;
        stall_cnt++;
        if (exp_cmd.size() > 0) chk("stall_addr", 64'(sdram_address), 64'(exp_cmd[0].addr));
      end else begin
        sdram_waitrequest = 1'b0;
        stall_cnt         = 0;
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", 64'(sdram_chipselect), 64'd0);
        end else begin
          c = exp_cmd.pop_front();
          chk("cmd_addr", 64'(sdram_address), 64'(c.addr));
          chk("cmd_write", 64'(!sdram_write_n), 64'(c.wr));
          chk("cmd_read", 64'(!sdram_read_n), 64'(!c.wr));
          chk("cmd_be_n", 64'(sdram_byteenable_n), 64'(c.be_n));
          if (c.wr) chk("cmd_wdata", 64'(sdram_writedata), 64'(c.wdata));
          rd_val = c.rdata;
          if (!c.wr && rd_lat > 0) rd_cnt = rd_lat;
        end
      end
    end else begin
      sdram_waitrequest = 1'b0;
      stall_cnt         = 0;
    end
  endtask

  task automatic req(input int ch, input logic wr, input logic rd,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [BE_W-1:0] be, input int due_rel, input logic err);
    cmd_t  c;
    done_t e;
    ch_addr[ch*ADDR_W +: ADDR_W]       = a;
    ch_writedata[ch*DATA_W +: DATA_W]  = wr ? d : ~d;
    ch_byteenable[ch*BE_W +: BE_W]     = be;
    ch_write[ch]                       = wr;
    ch_read[ch]                        = rd;
    c.addr  = a;
    c.wr    = wr;
    c.wdata = d;
    c.be_n  = ~be;
    c.rdata = d;
    exp_cmd.push_back(c);
    e.ch    = ch;
    e.rd    = rd && !wr;
    e.err   = err;
    e.rdata = d;
    e.due   = (due_rel < 0) ? -1 : cyc + due_rel;
    exp_done.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_done.size() != 0 || exp_cmd.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done_q", 64'(exp_done.size()), 64'd0);
    ch_read  = '0;
    ch_write = '0;
    exp_done.delete();
    exp_cmd.delete();
    repeat (2) tick();
  endtask

  task automatic rr_test();
    logic rearm_pend = 1'b0;
    logic rearmed    = 1'b0;
    int   n          = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      req(c, 1'b1, 1'b0, ADDR_W'(32'h100 + c), 32'hC0DE_0000 + 32'(c), 4'hF, -1, 1'b0);
    end
    while (exp_done.size() != 0 && n < 200) begin
      tick();
      n++;
      if (rearm_pend) begin
        req(0, 1'b1, 1'b0, 23'h000200, 32'h0BAD_F00D, 4'h3, -1, 1'b0);
        rearm_pend = 1'b0;
        rearmed    = 1'b1;
      end
      if (last_done == 0 && !rearmed) rearm_pend = 1'b1;
    end
    drain(100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n             = 1'b0;
    ch_addr             = '0;
    ch_read             = '0;
    ch_write            = '0;
    ch_writedata        = '0;
    ch_byteenable       = '0;
    sdram_readdata      = '0;
    sdram_readdatavalid = 1'b0;
    sdram_waitrequest   = 1'b0;
    repeat (3) tick();

    chk("rst_cs", 64'(sdram_chipselect), 64'd0);
    chk("rst_read_n", 64'(sdram_read_n), 64'd1);
    chk("rst_write_n", 64'(sdram_write_n), 64'd1);
    chk("rst_be_n", 64'(sdram_byteenable_n), 64'hF);
    chk("rst_addr", 64'(sdram_address), 64'd0);
    chk("rst_wdata", 64'(sdram_writedata), 64'd0);
    chk("rst_done", 64'(ch_done), 64'd0);
    chk("rst_err", 64'(ch_err), 64'd0);
    chk("rst_rdata", 64'(ch_readdata), 64'd0);
    i_rst_n = 1'b1;
    repeat (2) tick();

    // Single write, no stall: strobe in cycle 1, done in cycle 2.
    stall_cfg = 0;
    rd_lat    = 0;
    req(1, 1'b1, 1'b0, 23'h000010, 32'hDEADBEEF, 4'hF, 2, 1'b0);
    tick();
    chk("wr_strobe_c1", 64'(sdram_write_n), 64'd0);
    chk("wr_cs_c1", 64'(sdram_chipselect), 64'd1);
    drain(20);

    // Read with three stall cycles, data two cycles after acceptance.
    stall_cfg = 3;
    rd_lat    = 2;
    req(0, 1'b0, 1'b1, 23'h7FFFFF, 32'h12345678, 4'hF, 7, 1'b0);
    drain(30);

    // Read and write together: controller must see a write.
    stall_cfg = 0;
    req(2, 1'b1, 1'b1, 23'h2AAAAA, 32'hA5A50F0F, 4'b0101, 2, 1'b0);
    drain(20);

    // Partial byte enable read, one stall, data one cycle after acceptance.
    stall_cfg = 1;
    rd_lat    = 1;
    req(3, 1'b0, 1'b1, 23'h0055AA, 32'hCAFEF00D, 4'b1000, 4, 1'b0);
    drain(20);

    // Round robin with all four channels, channel 0 re-requesting.
    stall_cfg = 0;
    rr_test();

`ifdef SDRAM_ARB_TIMEOUT_EN
    stall_cfg = 0;
    rd_lat    = 0;
    req(3, 1'b0, 1'b1, 23'h000123, 32'h5555AAAA, 4'hF, TIMEOUT_CYC + 2, 1'b1);
    drain(60);
`endif

    // Reset in WAIT_RD: abandon, ignore the late read data, no done.
    stall_cfg = 0;
    rd_lat    = 5;
    req(0, 1'b0, 1'b1, 23'h000456, 32'hBAD0BAD0, 4'hF, -1, 1'b0);
    repeat (3) tick();
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 64'(sdram_chipselect), 64'd0);
    chk("mid_rst_read_n", 64'(sdram_read_n), 64'd1);
    chk("mid_rst_be_n", 64'(sdram_byteenable_n), 64'hF);
    chk("mid_rst_addr", 64'(sdram_address), 64'd0);
    chk("mid_rst_rdata", 64'(ch_readdata), 64'd0);
    chk("mid_rst_done", 64'(ch_done), 64'd0);
    ch_read  = '0;
    ch_write = '0;
    exp_done.delete();
    exp_cmd.delete();
    hold_rdata = '0;
    tick();
    i_rst_n = 1'b1;
    repeat (8) tick();
    chk("late_rdv_ignored", 64'(ch_readdata), 64'd0);
    chk("post_rst_cs", 64'(sdram_chipselect), 64'd0);

    // After reset channel 0 must beat channel 2; back-to-back latency.
    rd_lat = 0;
    req(0, 1'b1, 1'b0, 23'h001000, 32'h01020304, 4'hF, 2, 1'b0);
    req(2, 1'b1, 1'b0, 23'h002000, 32'h05060708, 4'b1100, 5, 1'b0);
    drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
